// File: rtl/reg_dump_tx.sv
// Debug read-out engine: walks the register file and sends each byte LSB-first as UART 8N1.
// Optional macro REG_DUMP_HEADER_EN prefixes every dump with a 0xA5 header frame.
module reg_dump_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int NUM_REGS     = 4,
    parameter int ADDR_W       = 2,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dump_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);
    localparam logic [2:0]        LAST_BIT  = 3'd7;
`ifdef REG_DUMP_HEADER_EN
    localparam logic [DATA_W-1:0] HEADER_BYTE = DATA_W'(8'hA5);
`endif

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        CAPTURE,
        START,
        DATA,
        STOP
    } state_t;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   rd_addr_n;
    logic                tx_n, busy_n, done_n;
    logic [DATA_W-1:0]   shift, shift_n;
    logic [2:0]          bit_cnt, bit_cnt_n;
    logic [BAUD_W-1:0]   baud_cnt, baud_n;
    logic [ADDR_W-1:0]   idx, idx_n;
    logic                baud_last;
`ifdef REG_DUMP_HEADER_EN
    logic                hdr, hdr_n;
`endif

    assign baud_last = (baud_cnt == BAUD_LAST);

    // tx is registered, so the comb block computes the line level for the coming cycle.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_n   = state;
        rd_addr_n = rd_addr;
        tx_n      = 1'b1;
        busy_n    = busy;
        done_n    = 1'b0;
        shift_n   = shift;
        bit_cnt_n = bit_cnt;
        baud_n    = baud_cnt;
        idx_n     = idx;
`ifdef REG_DUMP_HEADER_EN
        hdr_n     = hdr;
`endif
        case (state)
            IDLE: begin
                if (dump_req) begin
                    busy_n    = 1'b1;
                    rd_addr_n = '0;
                    idx_n     = '0;
`ifdef REG_DUMP_HEADER_EN
                    state_n   = START;
                    shift_n   = HEADER_BYTE;
                    hdr_n     = 1'b1;
                    baud_n    = '0;
                    tx_n      = 1'b0;
`else
                    state_n   = SETUP;
`endif
                end
            end
            SETUP: state_n = CAPTURE;
            CAPTURE: begin
                shift_n = rd_data;
                baud_n  = '0;
                state_n = START;
                tx_n    = 1'b0;
            end
            START: begin
                if (baud_last) begin
                    baud_n    = '0;
                    bit_cnt_n = '0;
                    state_n   = DATA;
                    tx_n      = shift[0];
                end else begin
                    baud_n = baud_cnt + 1'b1;
                    tx_n   = 1'b0;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_n  = '0;
                    shift_n = shift >> 1;
                    if (bit_cnt == LAST_BIT) begin
                        state_n = STOP;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                        tx_n      = shift[1];
                    end
                end else begin
                    baud_n = baud_cnt + 1'b1;
                    tx_n   = shift[0];
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_n = '0;
`ifdef REG_DUMP_HEADER_EN
                    if (hdr) begin
                        hdr_n   = 1'b0;
                        state_n = SETUP;
                    end else
`endif
                    if (idx < LAST_IDX) begin
                        idx_n     = idx + 1'b1;
                        rd_addr_n = idx + 1'b1;
                        state_n   = SETUP;
                    end else begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state    <= IDLE;
            rd_addr  <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            shift    <= '0;
            bit_cnt  <= '0;
            baud_cnt <= '0;
            idx      <= '0;
`ifdef REG_DUMP_HEADER_EN
            hdr      <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            rd_addr  <= rd_addr_n;
            tx       <= tx_n;
            busy     <= busy_n;
            done     <= done_n;
            shift    <= shift_n;
            bit_cnt  <= bit_cnt_n;
            baud_cnt <= baud_n;
            idx      <= idx_n;
`ifdef REG_DUMP_HEADER_EN
            hdr      <= hdr_n;
`endif
        end
    end

endmodule

// File: tb/tb_reg_dump_tx.sv
// Directed bench for reg_dump_tx: decodes the UART line and checks bytes, gaps, busy time and done.
// Expectations follow REG_DUMP_HEADER_EN when it is defined.
module tb_reg_dump_tx;

    localparam int CPB = 4;
    localparam int NR  = 4;
`ifdef REG_DUMP_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    localparam int NF              = NR + HDR;
    localparam int BUSY_EXP        = NR * (10 * CPB + 2) + HDR * 10 * CPB;
    localparam int FIRST_WAIT_PULSE = (HDR != 0) ? 0 : 2;
    localparam int FIRST_WAIT_HELD  = (HDR != 0) ? 1 : 3;

    logic       clk;
    logic       rst_n;
    logic       dump_req;
    logic [1:0] rd_addr;
    logic [7:0] rd_data;
    logic       tx;
    logic       busy;
    logic       done;

    logic [7:0] regs [NR];
    logic [7:0] expb [NF];

    int checks = 0;
    int errors = 0;

    reg_dump_tx #(
        .CLKS_PER_BIT(CPB),
        .NUM_REGS    (NR),
        .ADDR_W      (2),
        .DATA_W      (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .dump_req(dump_req),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .tx      (tx),
        .busy    (busy),
        .done    (done)
    );

    assign rd_data = regs[rd_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle-accurate bookkeeping of done pulses and the busy window of the latest dump.
    int   cyc = 0;
    int   done_cnt = 0;
    int   rise_cyc = 0;
    int   last_busy_time = 0;
    logic busy_q = 1'b0;
    always @(posedge clk) begin
        cyc    <= cyc + 1;
        busy_q <= busy;
        if (busy === 1'b1 && busy_q !== 1'b1) rise_cyc <= cyc;
        if (done === 1'b1) begin
            done_cnt       <= done_cnt + 1;
            last_busy_time <= cyc - rise_cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_regs(input logic [7:0] r0, input logic [7:0] r1,
                            input logic [7:0] r2, input logic [7:0] r3);
        regs[0] = r0; regs[1] = r1; regs[2] = r2; regs[3] = r3;
    endtask

    task automatic set_exp(input logic [7:0] r0, input logic [7:0] r1,
                           input logic [7:0] r2, input logic [7:0] r3);
`ifdef REG_DUMP_HEADER_EN
        expb[0] = 8'hA5;
`endif
        expb[HDR]     = r0;
        expb[HDR + 1] = r1;
        expb[HDR + 2] = r2;
        expb[HDR + 3] = r3;
    endtask

    // Returns the number of negedges until tx is seen low (bounded at 200).
    task automatic wait_start(output int waited);
        waited = 0;
        while (tx !== 1'b0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
    endtask

    // Entered on cycle 0 of a start bit; leaves on the last stop-bit cycle.
    task automatic rx_frame(output logic [7:0] b, output int low_len, output logic stop_b,
                            input bit pulse_req);
        b       = '0;
        low_len = 1;
        stop_b  = 1'bx;
        for (int c = 1; c < 10 * CPB; c++) begin
            @(negedge clk);
            if (pulse_req && c == 10) dump_req = 1'b1;
            if (pulse_req && c == 11) dump_req = 1'b0;
            if (c < CPB && tx === 1'b0) low_len++;
            if (c >= CPB && c < 9 * CPB && (c - CPB) % CPB == 1) b[(c - CPB) / CPB] = tx;
            if (c == 9 * CPB + 1) stop_b = tx;
        end
    endtask

    // mode 0: plain; mode 1: live writes + request mid frame 2; mode 2: drop held dump_req.
    task automatic run_dump(input int first_wait, input int mode);
        int         w;
        int         ll;
        logic [7:0] b;
        logic       sb;
        for (int f = 0; f < NF; f++) begin
            wait_start(w);
            check($sformatf("gap_f%0d", f), w, (f == 0) ? first_wait : 3);
            if (mode == 2 && f == 0) dump_req = 1'b0;
            if (mode == 1 && f == HDR) regs[3] = 8'h99;
            if (mode == 1 && f == HDR + 1) regs[0] = 8'h55;
            rx_frame(b, ll, sb, (mode == 1 && f == HDR + 2));
            check($sformatf("byte_f%0d", f), b, expb[f]);
            check($sformatf("start_len_f%0d", f), ll, CPB);
            check($sformatf("stop_f%0d", f), sb, 1'b1);
        end
        @(negedge clk);
        check("done_pulse", done, 1'b1);
        check("busy_end", busy, 1'b0);
    endtask

    initial begin
        int w;
        int ll;
        int dc0;
        int quiet;
        logic [7:0] b;
        logic sb;

        // Reset held with dump_req high: outputs stay idle.
        set_regs(8'h11, 8'h22, 8'h33, 8'h44);
        set_exp(8'h11, 8'h22, 8'h33, 8'h44);
        rst_n    = 1'b0;
        dump_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rst_tx_%0d", i), tx, 1'b1);
            check($sformatf("rst_busy_%0d", i), busy, 1'b0);
            check($sformatf("rst_done_%0d", i), done, 1'b0);
            check($sformatf("rst_addr_%0d", i), rd_addr, 2'd0);
        end

        // Release: the held request is accepted at the next edge, then dropped.
        dc0   = done_cnt;
        rst_n = 1'b1;
        @(negedge clk);
        dump_req = 1'b0;
        check("accept_busy", busy, 1'b1);
        check("accept_addr", rd_addr, 2'd0);
        check("accept_tx", tx, (HDR != 0) ? 1'b0 : 1'b1);
        run_dump(FIRST_WAIT_PULSE, 0);
        @(negedge clk);
        check("basic_done_cnt", done_cnt, dc0 + 1);
        check("basic_busy_time", last_busy_time, BUSY_EXP);
        check("addr_hold", rd_addr, 2'd3);

        // Live updates and an ignored request mid-dump.
        repeat (3) @(negedge clk);
        dc0 = done_cnt;
        set_exp(8'h11, 8'h22, 8'h33, 8'h99);
        dump_req = 1'b1;
        @(negedge clk);
        dump_req = 1'b0;
        run_dump(FIRST_WAIT_PULSE, 1);
        quiet = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) quiet++;
        end
        check("no_queued_dump", quiet, 0);
        check("live_done_cnt", done_cnt, dc0 + 1);
        check("live_busy_time", last_busy_time, BUSY_EXP);

        // Held-high request: back-to-back dumps.
        set_regs(8'h11, 8'h22, 8'h33, 8'h44);
        set_exp(8'h11, 8'h22, 8'h33, 8'h44);
        dc0 = done_cnt;
        dump_req = 1'b1;
        @(negedge clk);
        run_dump(FIRST_WAIT_PULSE, 0);
        run_dump(FIRST_WAIT_HELD, 2);
        @(negedge clk);
        check("held_done_cnt", done_cnt, dc0 + 2);
        check("held_busy_time", last_busy_time, BUSY_EXP);

        // Reset during DATA bit 4 of register frame 1.
        repeat (3) @(negedge clk);
        dump_req = 1'b1;
        @(negedge clk);
        dump_req = 1'b0;
        for (int f = 0; f <= HDR; f++) begin
            wait_start(w);
            rx_frame(b, ll, sb, 1'b0);
        end
        wait_start(w);
        check("pre_rst_gap", w, 3);
        repeat (4 * CPB + CPB + 1) @(negedge clk);
        dc0   = done_cnt;
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_tx", tx, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_addr", rd_addr, 2'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_no_done", done_cnt, dc0);
        dump_req = 1'b1;
        @(negedge clk);
        dump_req = 1'b0;
        run_dump(FIRST_WAIT_PULSE, 0);
        @(negedge clk);
        check("post_rst_done_cnt", done_cnt, dc0 + 1);
        check("post_rst_busy_time", last_busy_time, BUSY_EXP);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_dump_tx.md
Name: reg_dump_tx

Overview:
- Debug read-out engine for the 8-bit register file.
- On request, walks every register address through the file's asynchronous read port, captures each byte and transmits it LSB-first on a UART TX line (8N1).
- Sits beside the datapath, sharing a read address mux with the debug path.
- The file is written by the pipeline; this block is its off-chip reader.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit period (100 MHz / 115200). Legal range is 2 or more.
- NUM_REGS, 4, number of registers dumped, addresses 0 to NUM_REGS-1.
- ADDR_W, 2, register address width. NUM_REGS must be at most 2^ADDR_W.
- DATA_W, 8, register width. Fixed at 8 for UART framing.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- dump_req  input  1  start a dump. Sampled only in IDLE; level or pulse.
- rd_addr  output  ADDR_W  read address to the register file. Registered.
- rd_data  input  DATA_W  asynchronous read data from the register file for rd_addr.
- tx  output  1  UART serial out, idle high. Registered.
- busy  output  1  high from acceptance of dump_req until the last stop bit completes.
- done  output  1  one-cycle pulse when a dump completes.

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is synchronous and active-low.
- Reset values, taking effect on the first clk edge with rst_n=0:
  - state=IDLE, rd_addr=0, tx=1, busy=0, done=0.
  - shift register, bit counter, baud counter and register index all 0.
- States: IDLE, SETUP, CAPTURE, START, DATA, STOP.
- IDLE: tx=1. If dump_req=1 at edge T:
  - state becomes SETUP at T+1.
  - busy=1 and rd_addr=0 from T+1.
- SETUP: one cycle, lets rd_addr settle. Goes to CAPTURE.
- CAPTURE: one cycle.
  - shift register <= rd_data.
  - Baud counter cleared.
  - Goes to START.
- START: tx=0 for exactly CLKS_PER_BIT cycles, then DATA with bit counter 0.
- DATA: tx = shift[0] for CLKS_PER_BIT cycles per bit; shift right after each bit.
  - After 8 bits, goes to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. Then:
  - If index < NUM_REGS-1: index+1, rd_addr = index+1, go to SETUP.
  - Otherwise: go to IDLE, busy=0 and done=1 for that single cycle.
- Timing:
  - First start bit begins at T+3.
  - Each frame is 10*CLKS_PER_BIT cycles.
  - Inter-frame gap is 2 cycles of tx=1 (SETUP + CAPTURE).
  - Total busy time is NUM_REGS*(10*CLKS_PER_BIT+2) cycles.
- Baud counter counts 0 to CLKS_PER_BIT-1 and wraps. Its width is clog2(CLKS_PER_BIT).
- Boundary conditions:
  - dump_req while busy: ignored, not queued.
  - dump_req held high continuously: a new dump is accepted the cycle after done, i.e. back-to-back dumps.
  - No snapshot. Each register is captured in its own CAPTURE cycle, so a pipeline write to register k before its CAPTURE is reflected; a later write is not.
  - Reset mid-frame: tx=1 and IDLE at the next edge. The partial frame is abandoned and done is not pulsed.
  - NUM_REGS=1: single frame, then done.
- rd_addr holds its last value in IDLE and is not returned to 0 after a dump.

Optional Feature:
- Macro: REG_DUMP_HEADER_EN.
- When defined:
  - A HEADER frame carrying byte 0xA5 is sent before register 0.
  - Sequence: IDLE -> HEADER frame (start/data/stop, with shift loaded with 0xA5 on acceptance) -> SETUP -> ...
  - First start bit still begins at T+1 + 0 cycles, i.e. tx=0 at T+1.
  - Busy time gains 10*CLKS_PER_BIT cycles.
- When undefined: no header, timing as above.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with dump_req=1 -> tx=1, busy=0, done=0, rd_addr=0 throughout. Release -> dump starts on the next sampled dump_req.
- Basic dump: CLKS_PER_BIT=4, regs {0x11,0x22,0x33,0x44}, one-cycle dump_req -> decoded tx bytes 0x11,0x22,0x33,0x44, LSB first, each start bit 4 cycles low. done pulses once, exactly 4*(40+2)=168 cycles after busy rose.
- Live update: write reg3=0x99 during frame 0, then reg0=0x55 during frame 1 -> reg3 transmits 0x99, reg0 still transmits the original 0x11.
- Request while busy: pulse dump_req mid frame 2 -> no extra frames; exactly one done. Held-high dump_req -> second dump's start bit 3 cycles after done.
- Mid-frame reset: assert rst_n=0 during DATA bit 4 of frame 1 -> tx=1 and busy=0 next cycle, no done. A following dump transmits all 4 bytes correctly.
- Header (REG_DUMP_HEADER_EN defined): basic dump -> bytes 0xA5,0x11,0x22,0x33,0x44. Busy time is 208 cycles.
